mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the two-port memory arbiter.
//   port_t     : port tag carried through the pending-read pipeline
//                (PORT_A = 0, PORT_B = 1); also the type of the round-robin
//                last_grant register.
//   RD_LATENCY : clocks from grant to rvalid. The macro MEM_ARB_RDATA_REG_EN
//                adds an output register stage, making it 2; the default is 1.
package mem_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

`ifdef MEM_ARB_RDATA_REG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant logic (purely combinational).
//   req[1:0]   : requests, bit 0 = port A, bit 1 = port B
//   last_grant : port granted most recently
//   gnt[1:0]   : one-hot grant (or zero); a lone requester always wins, and
//                under contention the port that was not granted last wins.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between ports A and B.
//   clock, reset           : sole clock; synchronous active-high reset
//   a_* / b_*              : request ports (req, we, addr, wdata in;
//                            gnt, rvalid, rdata out)
//   ram_address/data/wren  : RAM command, driven by the granted port
//   ram_q                  : RAM read data, valid one clock after the address
// Optional feature: define MEM_ARB_RDATA_REG_EN to register rdata/rvalid once
// more (read latency 2 clocks instead of 1, throughput unchanged).
//
// Handshake: a port raises x_req with x_we/x_addr/x_wdata and holds them stable
// until x_gnt; x_gnt is combinational in the same cycle and the access is taken
// on the clock edge that ends that cycle. A new grant can be issued every cycle.
// Reads return on x_rvalid (one-cycle pulse) RD_LATENCY clocks after the grant;
// writes never produce an rvalid.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_SPACE-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_SPACE-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_SPACE-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic [1:0] arb_gnt;
  port_t      last_grant;
  logic       rd_pend;
  port_t      rd_tag;
  logic       ret_a;
  logic       ret_b;

  rr_arbiter2 u_arb (
    .req        ({b_req, a_req}),
    .last_grant (last_grant),
    .gnt        (arb_gnt)
  );

  // Reset masks the grants so nothing reaches the RAM while reset is high.
  assign a_gnt = ~reset & arb_gnt[0];
  assign b_gnt = ~reset & arb_gnt[1];

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (a_gnt) begin
      ram_address = a_addr;
      ram_data    = a_wdata;
      ram_wren    = a_we;
    end else if (b_gnt) begin
      ram_address = b_addr;
      ram_data    = b_wdata;
      ram_wren    = b_we;
    end
  end

  // last_grant only moves on an actual grant; idle cycles keep the fairness order.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PORT_B;
    end else if (a_gnt) begin
      last_grant <= PORT_A;
    end else if (b_gnt) begin
      last_grant <= PORT_B;
    end
  end

  // Pending-read stage: lines up with ram_q in the cycle after the grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_tag  <= PORT_A;
    end else begin
      rd_pend <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
      rd_tag  <= b_gnt ? PORT_B : PORT_A;
    end
  end

  assign ret_a = rd_pend & (rd_tag == PORT_A);
  assign ret_b = rd_pend & (rd_tag == PORT_B);

`ifdef MEM_ARB_RDATA_REG_EN
  logic                  a_rv_q;
  logic                  b_rv_q;
  logic [DATA_WIDTH-1:0] a_rd_q;
  logic [DATA_WIDTH-1:0] b_rd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      a_rv_q <= ret_a;
      b_rv_q <= ret_b;
      if (ret_a) a_rd_q <= ram_q;
      if (ret_b) b_rd_q <= ram_q;
    end
  end

  assign a_rvalid = ~reset & a_rv_q;
  assign b_rvalid = ~reset & b_rv_q;
  assign a_rdata  = reset ? '0 : a_rd_q;
  assign b_rdata  = reset ? '0 : b_rd_q;
`else
  // ram_q is passed straight through on the return cycle; the hold registers
  // keep the last returned word visible once rvalid drops.
  logic [DATA_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] b_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      if (ret_a) a_hold <= ram_q;
      if (ret_b) b_hold <= ram_q;
    end
  end

  assign a_rvalid = ~reset & ret_a;
  assign b_rvalid = ~reset & ret_b;
  assign a_rdata  = reset ? '0 : (ret_a ? ram_q : a_hold);
  assign b_rdata  = reset ? '0 : (ret_b ? ram_q : b_hold);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level model
// (memory array + queue of scheduled read returns).
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wren;
  logic [DW-1:0] a_rdata, b_rdata, ram_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q = '0;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Single-port RAM with registered read data.
  logic [DW-1:0] tb_ram [int];
  always @(posedge clock) begin
    logic [DW-1:0] rd;
    rd = tb_ram.exists(int'(ram_address)) ? tb_ram[int'(ram_address)] : '0;
    ram_q <= rd;
    if (ram_wren) tb_ram[int'(ram_address)] = ram_data;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int            due;
    logic          port;   // 0 = A, 1 = B
    logic [DW-1:0] data;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] mem_m [int];
  logic          m_last = 1'b1;        // B granted last, so A wins first contention
  logic [DW-1:0] m_hold_a = '0, m_hold_b = '0;
  int            cyc = 0;

  always @(negedge clock) begin
    logic ega, egb, erva, ervb, ewren;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    cyc++;
    if (reset) begin
      chk("rst_a_gnt", a_gnt, 0);     chk("rst_b_gnt", b_gnt, 0);
      chk("rst_wren", ram_wren, 0);   chk("rst_addr", ram_address, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
      exp_q.delete();
      m_last = 1'b1; m_hold_a = '0; m_hold_b = '0;
    end else begin
      ega = a_req && (!b_req || m_last == 1'b1);
      egb = b_req && !ega;
      eaddr = ega ? a_addr : (egb ? b_addr : '0);
      edata = ega ? a_wdata : (egb ? b_wdata : '0);
      ewren = ega ? a_we : (egb ? b_we : 1'b0);
      erva = 0; ervb = 0;
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        rd_t e;
        e = exp_q.pop_front();
        if (e.port == 1'b0) begin erva = 1; m_hold_a = e.data; end
        else begin ervb = 1; m_hold_b = e.data; end
      end
      chk("a_gnt", a_gnt, ega);       chk("b_gnt", b_gnt, egb);
      chk("ram_address", ram_address, eaddr);
      chk("ram_data", ram_data, edata);
      chk("ram_wren", ram_wren, ewren);
      chk("a_rvalid", a_rvalid, erva); chk("b_rvalid", b_rvalid, ervb);
      chk("a_rdata", a_rdata, m_hold_a); chk("b_rdata", b_rdata, m_hold_b);
      if (ega || egb) begin
        logic          p;
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        p = egb; we = ega ? a_we : b_we; ad = ega ? a_addr : b_addr; wd = ega ? a_wdata : b_wdata;
        m_last = p;
        if (we) mem_m[int'(ad)] = wd;
        else exp_q.push_back('{due: cyc + RD_LATENCY, port: p,
                               data: mem_m.exists(int'(ad)) ? mem_m[int'(ad)] : '0});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Waits out the extra latency stages, checking rvalid stays low meanwhile.
  task automatic wait_return(input logic port);
    for (int i = 1; i < RD_LATENCY; i++) begin
      sample();
      chk("early_rvalid", port ? b_rvalid : a_rvalid, 0);
      next_cycle();
    end
    sample();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ga, gb;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // A write 0xBEEF to 0x0010
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
    sample();
    chk("d_a_wr_gnt", a_gnt, 1); chk("d_a_wr_wren", ram_wren, 1);
    chk("d_a_wr_addr", ram_address, 16'h0010);
    next_cycle();
    // A read 0x0010 right after
    a_we = 0;
    sample();
    chk("d_a_rd_gnt", a_gnt, 1); chk("d_a_rd_wren", ram_wren, 0);
    chk("d_a_wr_no_rvalid", a_rvalid, 0);
    next_cycle();
    a_req = 0;
    wait_return(1'b0);
    chk("d_a_rd_rvalid", a_rvalid, 1); chk("d_a_rd_data", a_rdata, 16'hBEEF);
    next_cycle();

    // B write 0x1234 to 0x0020, then read back-to-back
    b_req = 1; b_we = 1; b_addr = 16'h0020; b_wdata = 16'h1234;
    sample();
    chk("d_b_wr_gnt", b_gnt, 1); chk("d_b_wr_wren", ram_wren, 1);
    next_cycle();
    b_we = 0;
    sample();
    chk("d_b_rd_gnt", b_gnt, 1); chk("d_b_wr_no_rvalid", b_rvalid, 0);
    next_cycle();
    b_req = 0;
    wait_return(1'b1);
    chk("d_b_rd_rvalid", b_rvalid, 1); chk("d_b_rd_data", b_rdata, 16'h1234);
    next_cycle();

    // Contention: both read for 4 cycles; B was last, so A,B,A,B
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("d_rr_a_gnt", a_gnt, (k % 2) == 0);
      chk("d_rr_b_gnt", b_gnt, (k % 2) == 1);
      if (k >= RD_LATENCY) begin
        chk("d_rr_a_rvalid", a_rvalid, ((k - RD_LATENCY) % 2) == 0);
        chk("d_rr_b_rvalid", b_rvalid, ((k - RD_LATENCY) % 2) == 1);
        if (a_rvalid) chk("d_rr_a_data", a_rdata, 16'hBEEF);
        if (b_rvalid) chk("d_rr_b_data", b_rdata, 16'h1234);
      end
      next_cycle();
    end
    a_req = 0; b_req = 0;
    repeat (3) next_cycle();

    // B read granted, reset the following cycle: the read is discarded
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    sample();
    chk("d_rst_b_gnt", b_gnt, 1);
    next_cycle();
    b_req = 0; reset = 1;
    sample();
    chk("d_rst_b_rvalid", b_rvalid, 0); chk("d_rst_b_rdata", b_rdata, 0);
    chk("d_rst_wren", ram_wren, 0);     chk("d_rst_addr", ram_address, 0);
    next_cycle();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("d_post_rst_b_rvalid", b_rvalid, 0);
      next_cycle();
    end

    // Randomized traffic, requests held until granted, occasional reset
    for (int n = 0; n < 3000; n++) begin
      sample();
      ga = a_gnt; gb = b_gnt;
      next_cycle();
      reset = ($urandom_range(0, 199) == 0);
      if (ga || !a_req) begin
        a_req = ($urandom_range(0, 99) < 65);
        a_we = 1'($urandom_range(0, 1));
        a_addr = 16'($urandom_range(0, 15));
        a_wdata = 16'($urandom);
      end
      if (gb || !b_req) begin
        b_req = ($urandom_range(0, 99) < 65);
        b_we = 1'($urandom_range(0, 1));
        b_addr = 16'($urandom_range(0, 15));
        b_wdata = 16'($urandom);
      end
    end
    reset = 0; a_req = 0; b_req = 0;
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
